score_bcd_tracker: RTL and testbench
====================================

# score_bcd_tracker

Parametrised score, high-score and digit-scan engine for the snake game. It edge-detects the raw collision flags internally, so no external posedge detector is needed. It counts apples in binary and N-digit BCD in lockstep, and freezes play on game over or win. It time-multiplexes the BCD digits onto one shared seven-segment decoder feed with leading-zero blanking. It sits between the collision block and the display decoders.

## Interface
Parameters:
- DIGITS, 3: number of BCD digits kept and scanned (1–4).
- MAX_SCORE, 70: score that ends the game as a win; must be < 10**DIGITS.
- SCAN_DIV, 10000: clk cycles each digit is shown before the scan advances (≥2).
- SCORE_W, $clog2(MAX_SCORE+1): width of binary score outputs (derived; not overridden).

Ports:
- clk  in  1  system clock; all state on rising edge.
- nRst  in  1  asynchronous active-low reset.
- sync_reset  in  1  synchronous game restart (level; acts every cycle held).
- good_coll  in  1  raw apple-collision flag (level, may stay high for many cycles).
- bad_coll  in  1  raw fatal-collision flag (level).
- score  out  SCORE_W  current binary score.
- high_score  out  SCORE_W  best score since nRst.
- bcd  out  4*DIGITS  current score in BCD; digit 0 in [3:0].
- game_over  out  1  high in OVER state.
- game_complete  out  1  high in WIN state.
- digit_sel  out  $clog2(DIGITS) (min 1)  index of digit currently driven.
- digit_out  out  4  BCD value of the selected digit.
- digit_en  out  1  0 when the selected digit is a leading zero (digit 0 always enabled).

## Operation
- FSM states: PLAY, OVER, WIN. Reset state is PLAY.
- Edge detection: registers good_prev and bad_prev sample the inputs each cycle.
  - good_rise = good_coll & ~good_prev.
  - bad_rise = bad_coll & ~bad_prev.
- PLAY transitions:
  - bad_rise: go to OVER; score unchanged.
  - good_rise, no bad_rise: score += 1, BCD += 1 with decimal carry through all digits in the same cycle. If the new score == MAX_SCORE, go to WIN.
  - good_rise and bad_rise in the same cycle: bad wins; go to OVER with no increment.
- OVER, WIN: score and BCD frozen; collision edges ignored.
- high_score update: on entry to OVER or WIN, high_score := max(high_score, score). Only that register update path exists.
- sync_reset, in any state, highest priority:
  - Next state PLAY; score and BCD cleared to 0.
  - Edge registers load the current inputs, so a flag already high is not counted as a rise.
  - high_score retained.
- Scan:
  - A divider counts 0..SCAN_DIV-1. On terminal count, digit_sel advances and wraps DIGITS-1 → 0.
  - Scan runs in all states and is not affected by sync_reset.
- digit_out = bcd nibble [digit_sel]. Combinational from registers.
- digit_en = 0 iff digit_sel ≠ 0 and every nibble at index ≥ digit_sel is 0.
- game_over and game_complete decode from state and are never both high.

## Timing
- Reset (nRst low, async) values:
  - score = 0, bcd = 0, high_score = 0.
  - game_over = 0, game_complete = 0.
  - digit_sel = 0, divider = 0, digit_out = 0, digit_en = 1.
  - good_prev = 0, bad_prev = 0.
- Collision latency: a flag first sampled high at edge k updates score/state at edge k; visible after edge k.
- Rise cadence: a held-high flag yields exactly one rise. A second rise requires at least one low sample.
- high_score latency: updates at the same edge as the OVER/WIN entry.
- Scan timing: digit_sel changes every SCAN_DIV cycles; a full scan takes DIGITS*SCAN_DIV cycles.
- Carry example: 099 → 100 in one edge; no intermediate BCD value is visible.
- nRst mid-game: all outputs go to reset values immediately; high_score is lost.
- Boundaries:
  - A score at MAX_SCORE-1 with simultaneous good and bad rise: OVER, score = MAX_SCORE-1.
  - score never exceeds MAX_SCORE.

## Test plan
- Reset, then 5 pulses of good_coll, each 3 cycles high and 2 low → score = 5, bcd = 0x005, game_over = 0, one increment per pulse.
- Hold good_coll high 50 cycles → score increments by exactly 1.
- Score at 9, then 99 (DIGITS=3, MAX_SCORE=200), one good pulse each → bcd = 0x010, then 0x100 in a single cycle.
- Score at 12, bad_coll rise → game_over = 1 next cycle, high_score = 12. Further good pulses leave score at 12. sync_reset → PLAY, score = 0, high_score = 12.
- MAX_SCORE=70, drive 70 pulses → game_complete = 1 on the 70th, high_score = 70. The 71st pulse is ignored.
- SCAN_DIV=4, score = 7 → digit_sel sequence 0,1,2 changes every 4 cycles. digit_en = 1,0,0. digit_out for digit 0 = 7.
- Simultaneous good and bad rise at score 3 → OVER, score = 3.

Source files
------------

// File: rtl/score_bcd_tracker.sv
// Score, high-score and BCD digit-scan engine for the snake game.
// Edge-detects raw collision flags, tracks binary/BCD score in lockstep and
// time-multiplexes the BCD digits onto one seven-segment decoder feed.
module score_bcd_tracker #(
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned MAX_SCORE = 70,
  parameter int unsigned SCAN_DIV  = 10000,
  parameter int unsigned SCORE_W   = $clog2(MAX_SCORE + 1),
  localparam int unsigned BCD_W    = 4 * DIGITS,
  localparam int unsigned SEL_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int unsigned DIV_W    = $clog2(SCAN_DIV)
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               sync_reset,
  input  logic               good_coll,
  input  logic               bad_coll,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [BCD_W-1:0]   bcd,
  output logic               game_over,
  output logic               game_complete,
  output logic [SEL_W-1:0]   digit_sel,
  output logic [3:0]         digit_out,
  output logic               digit_en
);

  typedef enum logic [1:0] {
    S_PLAY,
    S_OVER,
    S_WIN
  } state_t;

  state_t             state, state_nxt;
  logic               good_prev, bad_prev;
  logic               good_rise, bad_rise;
  logic [SCORE_W-1:0] score_nxt, high_nxt, score_inc, best;
  logic [BCD_W-1:0]   bcd_nxt, bcd_inc;
  logic               carry;
  logic [DIV_W-1:0]   div_cnt;
  logic               upper_nz;

  assign good_rise = good_coll & ~good_prev;
  assign bad_rise  = bad_coll & ~bad_prev;
  assign score_inc = score + SCORE_W'(1);
  assign best      = (score > high_score) ? score : high_score;

  // Decimal increment rippling the carry through every digit in one cycle
  always_comb begin
    bcd_inc = bcd;
    carry   = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Next-state and datapath update; sync_reset overrides everything
  always_comb begin
    state_nxt = state;
    score_nxt = score;
    bcd_nxt   = bcd;
    high_nxt  = high_score;
    if (sync_reset) begin
      state_nxt = S_PLAY;
      score_nxt = '0;
      bcd_nxt   = '0;
    end else begin
      case (state)
        S_PLAY: begin
          if (bad_rise) begin
            state_nxt = S_OVER;
            high_nxt  = best;
          end else if (good_rise) begin
            score_nxt = score_inc;
            bcd_nxt   = bcd_inc;
            if (score_inc == SCORE_W'(MAX_SCORE)) begin
              state_nxt = S_WIN;
              high_nxt  = (score_inc > high_score) ? score_inc : high_score;
            end
          end
        end
        S_OVER:  state_nxt = S_OVER;
        S_WIN:   state_nxt = S_WIN;
        default: state_nxt = S_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= S_PLAY;
      score         <= '0;
      bcd           <= '0;
      high_score    <= '0;
      good_prev     <= 1'b0;
      bad_prev      <= 1'b0;
      game_over     <= 1'b0;
      game_complete <= 1'b0;
    end else begin
      state         <= state_nxt;
      score         <= score_nxt;
      bcd           <= bcd_nxt;
      high_score    <= high_nxt;
      good_prev     <= good_coll;
      bad_prev      <= bad_coll;
      game_over     <= (state_nxt == S_OVER);
      game_complete <= (state_nxt == S_WIN);
    end
  end

  // Digit scan runs free of game state and sync_reset
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      div_cnt   <= '0;
      digit_sel <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt   <= '0;
      digit_sel <= (digit_sel == SEL_W'(DIGITS - 1)) ? '0 : digit_sel + SEL_W'(1);
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    digit_out = 4'd0;
    upper_nz  = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (digit_sel == SEL_W'(i)) digit_out = bcd[4*i +: 4];
      if ((SEL_W'(i) >= digit_sel) && (bcd[4*i +: 4] != 4'd0)) upper_nz = 1'b1;
    end
    digit_en = (digit_sel == '0) || upper_nz;
  end

endmodule

// File: tb/tb_score_bcd_tracker.sv
// Directed bench for score_bcd_tracker: a MAX_SCORE=70 instance and a
// MAX_SCORE=200 instance share stimulus; the latter covers decimal carry.
module tb_score_bcd_tracker;

  logic clk = 1'b0;
  logic nRst, sync_reset, good_coll, bad_coll;

  logic [6:0]  score_a, high_a;
  logic [11:0] bcd_a;
  logic        over_a, win_a, en_a;
  logic [1:0]  sel_a;
  logic [3:0]  dout_a;

  logic [7:0]  score_b, high_b;
  logic [11:0] bcd_b;
  logic        over_b, win_b, en_b;
  logic [1:0]  sel_b;
  logic [3:0]  dout_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_bcd_tracker #(.DIGITS(3), .MAX_SCORE(70), .SCAN_DIV(4)) u_dut (
    .clk(clk), .nRst(nRst), .sync_reset(sync_reset),
    .good_coll(good_coll), .bad_coll(bad_coll),
    .score(score_a), .high_score(high_a), .bcd(bcd_a),
    .game_over(over_a), .game_complete(win_a),
    .digit_sel(sel_a), .digit_out(dout_a), .digit_en(en_a)
  );

  score_bcd_tracker #(.DIGITS(3), .MAX_SCORE(200), .SCAN_DIV(4)) u_big (
    .clk(clk), .nRst(nRst), .sync_reset(sync_reset),
    .good_coll(good_coll), .bad_coll(bad_coll),
    .score(score_b), .high_score(high_b), .bcd(bcd_b),
    .game_over(over_b), .game_complete(win_b),
    .digit_sel(sel_b), .digit_out(dout_b), .digit_en(en_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    good_coll = 1'b1;
    repeat (hi) tick();
    good_coll = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic restart();
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
  endtask

  initial begin
    int n;
    nRst = 1'b0; sync_reset = 1'b0; good_coll = 1'b0; bad_coll = 1'b0;
    repeat (3) tick();
    check("rst_score", 32'(score_a), 32'd0);
    check("rst_bcd", 32'(bcd_a), 32'h000);
    check("rst_high", 32'(high_a), 32'd0);
    check("rst_over", 32'(over_a), 32'd0);
    check("rst_win", 32'(win_a), 32'd0);
    check("rst_sel", 32'(sel_a), 32'd0);
    check("rst_dout", 32'(dout_a), 32'd0);
    check("rst_en", 32'(en_a), 32'd1);
    nRst = 1'b1;
    tick();

    // First rise counts at the edge that samples it
    good_coll = 1'b1;
    tick();
    check("rise_latency", 32'(score_a), 32'd1);
    tick(); tick();
    good_coll = 1'b0;
    tick(); tick();
    check("one_per_pulse", 32'(score_a), 32'd1);
    repeat (4) pulse(3, 2);
    check("five_score", 32'(score_a), 32'd5);
    check("five_bcd", 32'(bcd_a), 32'h005);
    check("five_over", 32'(over_a), 32'd0);

    pulse(50, 2);
    check("held_high", 32'(score_a), 32'd6);

    // Scan with score 7: sync to the 0->1 transition then time each step
    pulse(1, 1);
    check("score7", 32'(score_a), 32'd7);
    n = 0;
    while (sel_a !== 2'd0 && n < 12) begin tick(); n++; end
    n = 0;
    while (sel_a !== 2'd1 && n < 12) begin tick(); n++; end
    check("scan_sync", 32'(sel_a), 32'd1);
    check("scan1_en", 32'(en_a), 32'd0);
    check("scan1_out", 32'(dout_a), 32'd0);
    repeat (3) tick();
    check("scan1_hold", 32'(sel_a), 32'd1);
    tick();
    check("scan2_sel", 32'(sel_a), 32'd2);
    check("scan2_en", 32'(en_a), 32'd0);
    repeat (4) tick();
    check("scan0_sel", 32'(sel_a), 32'd0);
    check("scan0_en", 32'(en_a), 32'd1);
    check("scan0_out", 32'(dout_a), 32'd7);

    // Game over at 12, frozen afterwards, restart keeps high score
    repeat (5) pulse(1, 1);
    check("score12", 32'(score_a), 32'd12);
    bad_coll = 1'b1;
    tick();
    check("over_set", 32'(over_a), 32'd1);
    check("over_high", 32'(high_a), 32'd12);
    check("over_win", 32'(win_a), 32'd0);
    bad_coll = 1'b0;
    repeat (2) pulse(1, 1);
    check("over_frozen", 32'(score_a), 32'd12);
    restart();
    check("restart_over", 32'(over_a), 32'd0);
    check("restart_score", 32'(score_a), 32'd0);
    check("restart_bcd", 32'(bcd_a), 32'h000);
    check("restart_high", 32'(high_a), 32'd12);

    // Flag already high during sync_reset is not a rise
    good_coll = 1'b1;
    restart();
    tick();
    check("sr_no_rise", 32'(score_a), 32'd0);
    good_coll = 1'b0;
    tick();

    // Simultaneous rise at 3: bad wins, high score keeps the larger value
    repeat (3) pulse(1, 1);
    good_coll = 1'b1; bad_coll = 1'b1;
    tick();
    check("sim3_over", 32'(over_a), 32'd1);
    check("sim3_score", 32'(score_a), 32'd3);
    check("sim3_high", 32'(high_a), 32'd12);
    good_coll = 1'b0; bad_coll = 1'b0;
    tick();
    restart();

    // Simultaneous rise at MAX_SCORE-1
    repeat (69) pulse(1, 1);
    check("score69", 32'(score_a), 32'd69);
    check("bcd69", 32'(bcd_a), 32'h069);
    good_coll = 1'b1; bad_coll = 1'b1;
    tick();
    check("sim69_over", 32'(over_a), 32'd1);
    check("sim69_win", 32'(win_a), 32'd0);
    check("sim69_score", 32'(score_a), 32'd69);
    check("sim69_high", 32'(high_a), 32'd69);
    good_coll = 1'b0; bad_coll = 1'b0;
    tick();
    restart();

    // Win on the 70th apple, 71st ignored
    repeat (69) pulse(1, 1);
    check("pre_win", 32'(win_a), 32'd0);
    good_coll = 1'b1;
    tick();
    check("win_set", 32'(win_a), 32'd1);
    check("win_over", 32'(over_a), 32'd0);
    check("win_score", 32'(score_a), 32'd70);
    check("win_bcd", 32'(bcd_a), 32'h070);
    check("win_high", 32'(high_a), 32'd70);
    good_coll = 1'b0;
    tick();
    pulse(1, 1);
    check("win_frozen", 32'(score_a), 32'd70);
    check("big_71", 32'(score_b), 32'd71);
    restart();

    // Decimal carry on the wide-score instance
    repeat (9) pulse(1, 1);
    check("bcd9", 32'(bcd_b), 32'h009);
    pulse(1, 1);
    check("bcd10", 32'(bcd_b), 32'h010);
    repeat (89) pulse(1, 1);
    check("bcd99", 32'(bcd_b), 32'h099);
    good_coll = 1'b1;
    tick();
    check("bcd100", 32'(bcd_b), 32'h100);
    check("score100", 32'(score_b), 32'd100);
    good_coll = 1'b0;
    tick();

    // Asynchronous reset mid-game clears everything including high score
    nRst = 1'b0;
    #1;
    check("arst_score", 32'(score_b), 32'd0);
    check("arst_bcd", 32'(bcd_b), 32'h000);
    check("arst_high", 32'(high_a), 32'd0);
    check("arst_sel", 32'(sel_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
